cnt_updown_mod: RTL and testbench
=================================

CNT_UPDOWN_MOD -- requirements
Module: cnt_updown_mod

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL provide parameter MAX_VAL, default 15, upper count bound. Legal range is 1 .. 2^WIDTH-1.
REQ-003 SHALL provide parameter SATURATE, default 0: 0 = wrap at bounds, 1 = hold at bounds.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port mode  input  2  counting mode: 00 down, 01 up, 10 bounce, 11 hold.
REQ-008 SHALL have port load  input  1  synchronous parallel load.
REQ-009 SHALL have port din  input  WIDTH  load value.
REQ-010 SHALL have port count  output  WIDTH  registered count value.
REQ-011 SHALL have port dir  output  1  registered current direction: 1 up, 0 down.
REQ-012 SHALL have port tc  output  1  registered terminal-count pulse.

Function
REQ-013 All state (count, dir, tc) SHALL update only on the rising edge of clk, except during reset.
REQ-014 Priority SHALL be: reset, then load, then en.
REQ-015 Load: count <= min(din, MAX_VAL).
  - tc <= 0.
  - dir is unchanged.
  - Load SHALL take effect regardless of en and mode.
REQ-016 en=0 and load=0: count SHALL hold and tc <= 0.
REQ-017 mode 01 with en=1, count<MAX_VAL: count <= count+1.
REQ-018 mode 01 with en=1, count==MAX_VAL:
  - SATURATE=0: count <= 0.
  - SATURATE=1: count holds.
  - In both cases tc <= 1.
REQ-019 mode 00 with en=1, count>0: count <= count-1.
REQ-020 mode 00 with en=1, count==0:
  - SATURATE=0: count <= MAX_VAL.
  - SATURATE=1: count holds.
  - In both cases tc <= 1.
REQ-021 mode 10 (bounce) with en=1, dir=1:
  - count<MAX_VAL: count <= count+1.
  - count==MAX_VAL: count <= MAX_VAL-1, dir <= 0, tc <= 1.
REQ-022 mode 10 (bounce) with en=1, dir=0:
  - count>0: count <= count-1.
  - count==0: count <= 1, dir <= 1, tc <= 1.
REQ-023 In mode 10, SATURATE SHALL be ignored.
REQ-024 mode 11: count SHALL hold and tc <= 0, regardless of en.
REQ-025 dir update rules:
  - dir <= 1 on every non-reset cycle with mode 01.
  - dir <= 0 on every non-reset cycle with mode 00.
  - These updates are independent of en and load.
  - In mode 11, dir holds.
  - In mode 10, dir changes only per REQ-021/REQ-022.
REQ-026 tc SHALL be 0 on every cycle not covered by REQ-018, REQ-020, REQ-021 or REQ-022. It SHALL therefore be a one-cycle pulse per bound event, except that it stays high continuously while saturated with en=1.
REQ-027 Arithmetic SHALL be modulo MAX_VAL+1; count SHALL never exceed MAX_VAL.
REQ-028 A mode change takes effect on the same edge it is sampled. Bounce entry continues in the current dir.

Reset
REQ-029 reset=0 SHALL immediately force count=0, dir=1, tc=0, without waiting for a clock edge.
REQ-030 Release of reset SHALL be sampled synchronously to clk. The first count step SHALL occur on the first rising edge with reset=1.
REQ-031 Reset asserted mid-count or mid-load SHALL override all other inputs. No partial update is permitted.

Verification (WIDTH=4, MAX_VAL=9 unless stated)
REQ-032 Up wrap: mode=01, en=1 from count=0, 10 edges -> count 1..9 then 0; tc=1 only in the cycle count=0; dir=1.
REQ-033 Down wrap: mode=00, en=1 from count=0 -> count=9 with tc=1; then 8, 7 with tc=0; dir=0.
REQ-034 Saturate (SATURATE=1): mode=01, en=1 from count=8 -> count 9, 9, 9; tc=0, 1, 1. Then mode=00 -> 8 with tc=0.
REQ-035 Bounce: mode=10, dir=1, count=8 -> count 9, 8, 7; dir 1, 0, 0; tc=1 only with count=8. Continuing to 0 -> next count=1, dir=1, tc=1.
REQ-036 Load clamp/priority: load=1, din=12, en=1, mode=01 -> count=9, tc=0. Then load=1, din=3 -> count=3.
REQ-037 Async reset: assert reset=0 between edges with count=6 -> count=0, dir=1, tc=0 before the next edge. Deassert, then en=1, mode=01 -> count=1 on the following edge.

Source files
------------

// File: rtl/cnt_updown_mod.sv
// cnt_updown_mod: parameterised up/down/bounce counter with parallel load.
//
// The counter runs over 0 .. MAX_VAL. Up and down modes either wrap at
// the bounds or stick there (SATURATE). Bounce mode ping-pongs between
// the bounds and ignores SATURATE. The current direction is kept in the
// 'dir' register, which is also the only piece of control state the block
// has, so it is exposed directly as an output.
//
// Priority on every rising clock edge: reset (asynchronous, active low),
// then load, then en. In modes 00 and 01 'dir' follows the mode on every
// clock edge, whatever en and load are doing. In mode 10 it flips only
// when a bound is hit. In mode 11 it holds.
//
// tc is registered. It pulses for one cycle each time a bound event is
// taken. It stays high while the counter sits saturated with en=1.

module cnt_updown_mod #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 15,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc
);

    // Counting modes as presented on the 'mode' input.
    localparam logic [1:0] MODE_DOWN   = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    // Bound constants sized to the counter.
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = '0;
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] count_nxt;
    logic             at_max;
    logic             at_min;
    logic             bounce_turn;
    logic             dir_nxt;
    logic             tc_nxt;

    // Clamp the load value so the count can never exceed MAX_VAL.
    always_comb begin
        load_val = (din > MAX_C) ? MAX_C : din;
    end

    // Bound detection and the plain +1 / -1 neighbours of the count.
    // The neighbours are only selected away from the bounds, so they
    // never need to wrap on their own.
    always_comb begin
        at_max    = (count == MAX_C);
        at_min    = (count == ZERO_C);
        count_inc = count + ONE_C;
        count_dec = count - ONE_C;
    end

    // Bounce turns around when it reaches the bound it is heading for.
    always_comb begin
        bounce_turn = dir ? at_max : at_min;
    end

    // Next count and terminal-count flag. Load wins over en; with neither
    // asserted the count holds and tc drops.
    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        if (load) begin
            count_nxt = load_val;
        end else if (en) begin
            case (mode)
                MODE_UP: begin
                    if (at_max) begin
                        tc_nxt    = 1'b1;
                        count_nxt = SATURATE ? count : ZERO_C;
                    end else begin
                        count_nxt = count_inc;
                    end
                end
                MODE_DOWN: begin
                    if (at_min) begin
                        tc_nxt    = 1'b1;
                        count_nxt = SATURATE ? count : MAX_C;
                    end else begin
                        count_nxt = count_dec;
                    end
                end
                MODE_BOUNCE: begin
                    if (dir) begin
                        if (at_max) begin
                            tc_nxt    = 1'b1;
                            count_nxt = MAX_C - ONE_C;
                        end else begin
                            count_nxt = count_inc;
                        end
                    end else begin
                        if (at_min) begin
                            tc_nxt    = 1'b1;
                            count_nxt = ONE_C;
                        end else begin
                            count_nxt = count_dec;
                        end
                    end
                end
                MODE_HOLD: begin
                    count_nxt = count;
                end
                default: begin
                    count_nxt = count;
                end
            endcase
        end
    end

    // Next direction. Up and down modes force dir every edge. Bounce flips
    // it only on a counted bound hit. A load in bounce mode leaves it alone.
    always_comb begin
        dir_nxt = dir;
        case (mode)
            MODE_UP:     dir_nxt = 1'b1;
            MODE_DOWN:   dir_nxt = 1'b0;
            MODE_BOUNCE: begin
                if (!load && en && bounce_turn) begin
                    dir_nxt = ~dir;
                end
            end
            default:     dir_nxt = dir;
        endcase
    end

    // State registers; reset forces the idle state immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= ZERO_C;
            dir   <= 1'b1;
            tc    <= 1'b0;
        end else begin
            count <= count_nxt;
            dir   <= dir_nxt;
            tc    <= tc_nxt;
        end
    end

endmodule

// File: tb/tb_cnt_updown_mod.sv
// Testbench for cnt_updown_mod. Two instances share the same inputs: one
// wraps at the bounds and the other saturates. A behavioural model written
// with plain integer arithmetic tracks both of them. A compare process
// checks every output on every falling edge. Directed sequences with
// hand-computed literal values pin the model, then randomized traffic
// follows.

module tb_cnt_updown_mod;

    localparam int WIDTH   = 4;
    localparam int MAX_VAL = 9;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             en    = 1'b0;
    logic [1:0]       mode  = 2'b11;
    logic             load  = 1'b0;
    logic [WIDTH-1:0] din   = '0;

    logic [WIDTH-1:0] count_w, count_s;
    logic             dir_w, dir_s;
    logic             tc_w, tc_s;

    int n_vec = 0;
    int n_err = 0;

    // Model state, index 0 = wrapping instance, 1 = saturating instance.
    int m_count [2] = '{0, 0};
    bit m_dir   [2] = '{1'b1, 1'b1};
    bit m_tc    [2] = '{1'b0, 1'b0};

    // Clock and reset block.
    always #5 clk = ~clk;

    cnt_updown_mod #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .SATURATE(1'b0)) dut_w (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .load  (load),
        .din   (din),
        .count (count_w),
        .dir   (dir_w),
        .tc    (tc_w)
    );

    cnt_updown_mod #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .SATURATE(1'b1)) dut_s (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .load  (load),
        .din   (din),
        .count (count_s),
        .dir   (dir_s),
        .tc    (tc_s)
    );

    // One comparison with counting and reporting.
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural next-state rule for one instance, from the counting rules.
    function automatic void model_step(int s);
        int c;
        bit d;
        bit t;
        bit sat;
        c   = m_count[s];
        d   = m_dir[s];
        t   = 1'b0;
        sat = (s == 1);
        if (load) begin
            c = (int'(din) > MAX_VAL) ? MAX_VAL : int'(din);
        end else if (en) begin
            case (mode)
                2'b01: begin
                    t = (c == MAX_VAL);
                    if (!(t && sat)) c = (c + 1) % (MAX_VAL + 1);
                end
                2'b00: begin
                    t = (c == 0);
                    if (!(t && sat)) c = (c + MAX_VAL) % (MAX_VAL + 1);
                end
                2'b10: begin
                    if (d) begin
                        if (c == MAX_VAL) begin c = MAX_VAL - 1; d = 1'b0; t = 1'b1; end
                        else c = c + 1;
                    end else begin
                        if (c == 0) begin c = 1; d = 1'b1; t = 1'b1; end
                        else c = c - 1;
                    end
                end
                default: ;
            endcase
        end
        if (mode == 2'b01) d = 1'b1;
        else if (mode == 2'b00) d = 1'b0;
        m_count[s] = c;
        m_dir[s]   = d;
        m_tc[s]    = t;
    endfunction

    // Model advances on the same events as the design.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                m_count[s] = 0;
                m_dir[s]   = 1'b1;
                m_tc[s]    = 1'b0;
            end
        end else begin
            for (int s = 0; s < 2; s++) model_step(s);
        end
    end

    // Scoreboard compare: every output of both instances, every cycle.
    always @(negedge clk) begin
        check("model_count_w", 32'(count_w), 32'(m_count[0]));
        check("model_dir_w",   32'(dir_w),   32'(m_dir[0]));
        check("model_tc_w",    32'(tc_w),    32'(m_tc[0]));
        check("model_count_s", 32'(count_s), 32'(m_count[1]));
        check("model_dir_s",   32'(dir_s),   32'(m_dir[1]));
        check("model_tc_s",    32'(tc_s),    32'(m_tc[1]));
    end

    // Driver helpers.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit_w(input string nm, input int c, input bit d, input bit t);
        check({nm, "_count_w"}, 32'(count_w), 32'(c));
        check({nm, "_dir_w"},   32'(dir_w),   32'(d));
        check({nm, "_tc_w"},    32'(tc_w),    32'(t));
    endtask

    task automatic lit_s(input string nm, input int c, input bit d, input bit t);
        check({nm, "_count_s"}, 32'(count_s), 32'(c));
        check({nm, "_dir_s"},   32'(dir_s),   32'(d));
        check({nm, "_tc_s"},    32'(tc_s),    32'(t));
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        lit_w("rst", 0, 1'b1, 1'b0);
        lit_s("rst", 0, 1'b1, 1'b0);
        reset = 1'b1;

        // Up wrap from 0: 1..9 then 0 with tc.
        mode = 2'b01;
        en   = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            lit_w($sformatf("up%0d", i), i % 10, 1'b1, (i == 10));
        end

        // Down wrap from 0: 9 with tc, then 8, 7.
        mode = 2'b00;
        cyc(); lit_w("dn0", 9, 1'b0, 1'b1);
        cyc(); lit_w("dn1", 8, 1'b0, 1'b0);
        cyc(); lit_w("dn2", 7, 1'b0, 1'b0);

        // Saturation from 8 on the saturating instance.
        load = 1'b1; din = 4'd8; mode = 2'b01;
        cyc(); lit_s("sat_ld", 8, 1'b1, 1'b0);
        load = 1'b0;
        cyc(); lit_s("sat0", 9, 1'b1, 1'b0);
        cyc(); lit_s("sat1", 9, 1'b1, 1'b1);
        cyc(); lit_s("sat2", 9, 1'b1, 1'b1);
        mode = 2'b00;
        cyc(); lit_s("sat3", 8, 1'b0, 1'b0);

        // Bounce from 8 going up, through the top and down to the bottom.
        load = 1'b1; din = 4'd8; mode = 2'b01;
        cyc();
        load = 1'b0; mode = 2'b10;
        cyc(); lit_w("bnc0", 9, 1'b1, 1'b0); lit_s("bnc0", 9, 1'b1, 1'b0);
        cyc(); lit_w("bnc1", 8, 1'b0, 1'b1); lit_s("bnc1", 8, 1'b0, 1'b1);
        cyc(); lit_w("bnc2", 7, 1'b0, 1'b0);
        repeat (7) cyc();
        lit_w("bnc_bot", 0, 1'b0, 1'b0);
        cyc(); lit_w("bnc_up", 1, 1'b1, 1'b1); lit_s("bnc_up", 1, 1'b1, 1'b1);

        // Load clamp and priority over en.
        load = 1'b1; din = 4'd12; mode = 2'b01; en = 1'b1;
        cyc(); lit_w("clamp", 9, 1'b1, 1'b0); lit_s("clamp", 9, 1'b1, 1'b0);
        din = 4'd3;
        cyc(); lit_w("ld3", 3, 1'b1, 1'b0);

        // Asynchronous reset between edges.
        din = 4'd6; mode = 2'b00;
        cyc(); lit_w("pre_rst", 6, 1'b0, 1'b0);
        load = 1'b0; en = 1'b0; mode = 2'b11;
        #2 reset = 1'b0;
        #1 lit_w("arst", 0, 1'b1, 1'b0);
        lit_s("arst", 0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1; en = 1'b1; mode = 2'b01;
        cyc(); lit_w("post_rst", 1, 1'b1, 1'b0);

        // Randomized traffic; the compare process does the checking.
        repeat (3000) begin
            en   = ($urandom_range(0, 3) != 0);
            mode = 2'($urandom_range(0, 3));
            load = ($urandom_range(0, 7) == 0);
            din  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end else begin
                cyc();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
